// File: rtl/lcd_pcf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pcf_pkg : shared types and constants for the PCF8574 LCD link      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package lcd_pcf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_ACK   = 3'd3,
    ST_STOP  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  localparam int unsigned PCF_BL = 3;
  localparam int unsigned PCF_EN = 2;
  localparam int unsigned PCF_RW = 1;
  localparam int unsigned PCF_RS = 0;

  localparam int unsigned HOLD_SHORT_US = 50;
  localparam int unsigned HOLD_LONG_US  = 2000;

  // Expander port image: nibble on P7..P4, control pins below it.
  function automatic logic [7:0] pcf_byte(input logic [3:0] nib, input logic bl,
                                          input logic en, input logic rs);
    logic [7:0] b;
    b         = {nib, 4'b0000};
    b[PCF_BL] = bl;
    b[PCF_EN] = en;
    b[PCF_RW] = 1'b0;
    b[PCF_RS] = rs;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_pcf_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pcf_tick : quarter-bit tick and phase counter with stretch stall   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module lcd_pcf_tick #(
  parameter int unsigned Q_CYCLES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       stall,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CW = (Q_CYCLES > 1) ? $clog2(Q_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(Q_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  always_comb begin
    tick    = en & ~stall & (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end else if (!stall) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/lcd_pcf8574_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pcf8574_tx : HD44780 4-bit byte/nibble writer over PCF8574 I2C     |
// | Option: LCD_PCF_CLK_STRETCH_EN enables slave clock-stretch stalls.     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module lcd_pcf8574_tx
  import lcd_pcf_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned I2C_HZ   = 100_000,
  parameter logic [6:0]  I2C_ADDR = 7'h27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_nib,
  input  logic       in_bl,
  output logic       busy,
  output logic       nack,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int unsigned Q_CYC          = CLK_HZ / (4 * I2C_HZ);
  localparam int unsigned CYC_PER_US     = CLK_HZ / 1_000_000;
  localparam int unsigned HOLD_SHORT_CYC = CYC_PER_US * HOLD_SHORT_US;
  localparam int unsigned HOLD_LONG_CYC  = CYC_PER_US * HOLD_LONG_US;
  localparam int unsigned HOLD_W         = $clog2(HOLD_LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_SHORT_LD = HOLD_W'(HOLD_SHORT_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LONG_LD  = HOLD_W'(HOLD_LONG_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic              rs_q, rs_d, nib_q, nib_d, bl_q, bl_d, long_q, long_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_q, bit_d, byte_q, byte_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              nack_q, nack_d;
  logic              sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;

  logic       tick, tick_en, stall, phase_end, ack_smp, sda_in;
  logic [1:0] phase;
  logic [2:0] byte_idx, last_byte;
  logic [3:0] nib_sel;
  logic [7:0] next_byte;

  assign tick_en   = (state_q == ST_START) | (state_q == ST_BIT) |
                     (state_q == ST_ACK)   | (state_q == ST_STOP);
  assign phase_end = tick & (phase == 2'd3);
  assign ack_smp   = tick & (phase == 2'd2) & (state_q == ST_ACK);
  assign sda_in    = sda;
  assign last_byte = nib_q ? 3'd2 : 3'd4;

`ifdef LCD_PCF_CLK_STRETCH_EN
  // Only a low SCL that we are not driving ourselves counts as a stretch.
  assign stall = tick_en & phase[1] & ~scl_oe_q & ~scl;
`else
  assign stall = 1'b0;
`endif

  lcd_pcf_tick #(.Q_CYCLES(Q_CYC)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .stall (stall),
    .tick  (tick),
    .phase (phase)
  );

  // Data bytes 1..4: odd index raises EN, even index drops it; 3..4 carry the low nibble.
  always_comb begin
    byte_idx  = byte_q + 3'd1;
    nib_sel   = (byte_idx >= 3'd3) ? data_q[3:0] : data_q[7:4];
    next_byte = pcf_byte(nib_sel, bl_q, byte_idx[0], rs_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_START;
      ST_START: if (phase_end) state_d = ST_BIT;
      ST_BIT:   if (phase_end && bit_q == 3'd7) state_d = ST_ACK;
      ST_ACK:   if (phase_end) state_d = (nack_q || byte_q == last_byte) ? ST_STOP : ST_BIT;
      ST_STOP:  if (phase_end) state_d = nack_q ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (hold_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;   rs_d   = rs_q;   nib_d  = nib_q;  bl_d   = bl_q;
    long_d  = long_q;   shift_d = shift_q; bit_d = bit_q; byte_d = byte_q;
    hold_d  = hold_q;   nack_d = nack_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        data_d = in_data;
        rs_d   = in_rs;
        nib_d  = in_nib;
        bl_d   = in_bl;
        long_d = ~in_rs & ~in_nib & ((in_data == 8'h01) | (in_data == 8'h02));
        nack_d = 1'b0;
        byte_d = 3'd0;
      end
      ST_START: if (phase_end) begin
        shift_d = {I2C_ADDR, 1'b0};
        bit_d   = 3'd0;
      end
      ST_BIT: if (phase_end) begin
        shift_d = {shift_q[6:0], 1'b0};
        bit_d   = bit_q + 3'd1;
      end
      ST_ACK: begin
        if (ack_smp && sda_in) nack_d = 1'b1;
        if (phase_end && !nack_q && byte_q != last_byte) begin
          byte_d  = byte_idx;
          shift_d = next_byte;
          bit_d   = 3'd0;
        end
      end
      ST_STOP: if (phase_end) hold_d = long_q ? HOLD_LONG_LD : HOLD_SHORT_LD;
      ST_HOLD: if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
      default: ;
    endcase
  end

  always_comb begin
    sda_oe_d = 1'b0;
    scl_oe_d = 1'b0;
    case (state_q)
      ST_START: sda_oe_d = phase[1];
      ST_BIT: begin
        scl_oe_d = ~phase[1];
        sda_oe_d = ~shift_q[7];
      end
      ST_ACK:   scl_oe_d = ~phase[1];
      ST_STOP: begin
        sda_oe_d = ~phase[1];
        scl_oe_d = (phase == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      nib_q    <= 1'b0;
      bl_q     <= 1'b0;
      long_q   <= 1'b0;
      shift_q  <= 8'h00;
      bit_q    <= 3'd0;
      byte_q   <= 3'd0;
      hold_q   <= '0;
      nack_q   <= 1'b0;
      sda_oe_q <= 1'b0;
      scl_oe_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      rs_q     <= rs_d;
      nib_q    <= nib_d;
      bl_q     <= bl_d;
      long_q   <= long_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      hold_q   <= hold_d;
      nack_q   <= nack_d;
      sda_oe_q <= sda_oe_d;
      scl_oe_q <= scl_oe_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign nack     = nack_q;
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign scl      = scl_oe_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_lcd_pcf8574_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_pcf8574_tx : directed bench with an I2C slave/bus monitor       |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_lcd_pcf8574_tx;

  // Scaled clocking: Q = 8e6/(4*200e3) = 10 cycles, 8 cycles per microsecond.
  localparam int Q      = 10;
  localparam int HOLD_S = 8 * 50;
  localparam int HOLD_L = 8 * 2000;
  localparam int BYTE_FRAME = 188 * Q;
  localparam int NIB_FRAME  = 116 * Q;
  localparam int NACK_FRAME = 44 * Q;

  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0, in_nib = 1'b0, in_bl = 1'b0;
  logic       in_ready, busy, nack;
  wire        sda, scl;
  logic       sda_drv_low = 1'b0, scl_drv_low = 1'b0, ack_en = 1'b1;

  assign sda = sda_drv_low ? 1'b0 : 1'bz;
  assign scl = scl_drv_low ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (scl);

  lcd_pcf8574_tx #(
    .CLK_HZ   (8_000_000),
    .I2C_HZ   (200_000),
    .I2C_ADDR (7'h27)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_rs    (in_rs),
    .in_nib   (in_nib),
    .in_bl    (in_bl),
    .busy     (busy),
    .nack     (nack),
    .sda      (sda),
    .scl      (scl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bytes_q[$];
  int         n_start = 0, n_stop = 0, t_start = 0, t_acc = 0;
  int         n_cmp = 0, n_bad = 0;

  // Bus monitor and acknowledging slave.
  initial begin
    logic       prev_sda, prev_scl;
    logic [7:0] shreg;
    int         bitcnt;
    prev_sda = 1'b1; prev_scl = 1'b1; shreg = 8'h00; bitcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bitcnt      = 0;
        sda_drv_low = 1'b0;
      end else if (prev_scl && scl && prev_sda && !sda) begin
        n_start++;
        t_start = cyc;
        bitcnt  = 0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        n_stop++;
        bitcnt = 0;
      end else if (!prev_scl && scl) begin
        if (bitcnt < 8) shreg = {shreg[6:0], sda};
        bitcnt++;
        if (bitcnt == 8) bytes_q.push_back(shreg);
      end else if (prev_scl && !scl) begin
        if (bitcnt == 8 && ack_en) sda_drv_low = 1'b1;
        else if (bitcnt == 9) begin
          sda_drv_low = 1'b0;
          bitcnt      = 0;
        end
      end
      prev_sda = sda;
      prev_scl = scl;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic rs, input logic nib, input logic bl);
    @(negedge clk);
    check_eq("ready_at_accept", in_ready, 1'b1);
    in_data = d; in_rs = rs; in_nib = nib; in_bl = bl; in_valid = 1'b1;
    @(posedge clk);
    #1;
    t_acc    = cyc;
    in_valid = 1'b0;
    in_data  = ~d; in_rs = ~rs; in_nib = ~nib; in_bl = ~bl;
  endtask

  task automatic wait_idle(input string tag, input int limit, output int dur);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    dur = cyc - t_acc;
    check_eq({tag, "_idle"}, busy, 1'b0);
    check_eq({tag, "_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_bytes(input string tag, input int base, input int n,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0]  e [5];
    logic [31:0] got;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    check_eq({tag, "_nbytes"}, bytes_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < bytes_q.size()) ? {24'h0, bytes_q[base + i]} : 32'hDEAD;
      check_eq($sformatf("%s_byte%0d", tag, i), got, {24'h0, e[i]});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (busy=%0b)", busy);
    $fatal(1);
  end

  initial begin
    int dur, b, s;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", in_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_nack", nack, 1'b0);
    check_eq("rst_sda", sda, 1'b1);
    check_eq("rst_scl", scl, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Data byte 0x50, RS=1, BL=1.
    b = bytes_q.size(); s = n_stop;
    send(8'h50, 1'b1, 1'b0, 1'b1);
    wait_idle("t1", 40000, dur);
    check_eq("t1_busy_len", dur, BYTE_FRAME + HOLD_S);
    check_eq("t1_start_lat", t_start - t_acc, 2 * Q + 1);
    check_eq("t1_stop", n_stop - s, 1);
    check_eq("t1_nack", nack, 1'b0);
    check_bytes("t1", b, 5, 8'h4E, 8'h5D, 8'h59, 8'h0D, 8'h09);

    // Clear display: long hold.
    b = bytes_q.size();
    send(8'h01, 1'b0, 1'b0, 1'b1);
    wait_idle("t2", 40000, dur);
    check_eq("t2_busy_len", dur, BYTE_FRAME + HOLD_L);
    check_bytes("t2", b, 5, 8'h4E, 8'h0C, 8'h08, 8'h1C, 8'h18);

    // Nibble 0x30 (init), short hold.
    b = bytes_q.size();
    send(8'h30, 1'b0, 1'b1, 1'b0);
    wait_idle("t3", 40000, dur);
    check_eq("t3_busy_len", dur, NIB_FRAME + HOLD_S);
    check_bytes("t3", b, 3, 8'h4E, 8'h34, 8'h30, 8'h00, 8'h00);

    // Nibble with data 0x02: long hold applies in byte mode only.
    b = bytes_q.size();
    send(8'h02, 1'b0, 1'b1, 1'b1);
    wait_idle("t4", 40000, dur);
    check_eq("t4_busy_len", dur, NIB_FRAME + HOLD_S);
    check_bytes("t4", b, 3, 8'h4E, 8'h0C, 8'h08, 8'h00, 8'h00);

    // Data (RS=1) 0x01 is a character, not clear: short hold.
    b = bytes_q.size();
    send(8'h01, 1'b1, 1'b0, 1'b0);
    wait_idle("t5", 40000, dur);
    check_eq("t5_busy_len", dur, BYTE_FRAME + HOLD_S);
    check_bytes("t5", b, 5, 8'h4E, 8'h05, 8'h01, 8'h15, 8'h11);

    // Address NACK: STOP, sticky nack, no hold.
    ack_en = 1'b0;
    b = bytes_q.size(); s = n_stop;
    send(8'h50, 1'b1, 1'b0, 1'b1);
    wait_idle("t6", 40000, dur);
    check_eq("t6_busy_len", dur, NACK_FRAME);
    check_eq("t6_nack", nack, 1'b1);
    check_eq("t6_stop", n_stop - s, 1);
    check_bytes("t6", b, 1, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h00);

    // Next accept clears nack; return-home also takes the long hold.
    ack_en = 1'b1;
    b = bytes_q.size();
    send(8'h02, 1'b0, 1'b0, 1'b1);
    check_eq("t7_nack_clr", nack, 1'b0);
    wait_idle("t7", 40000, dur);
    check_eq("t7_busy_len", dur, BYTE_FRAME + HOLD_L);
    check_eq("t7_nack", nack, 1'b0);
    check_bytes("t7", b, 5, 8'h4E, 8'h0C, 8'h08, 8'h2C, 8'h28);

    // Reset in the middle of the first address bit.
    send(8'h50, 1'b1, 1'b0, 1'b1);
    while (cyc < t_acc + 45) @(negedge clk);
    check_eq("t8_scl_low_pre", scl, 1'b0);
    check_eq("t8_sda_low_pre", sda, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t8_sda_rel", sda, 1'b1);
    check_eq("t8_scl_rel", scl, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t8_ready", in_ready, 1'b1);
    check_eq("t8_busy", busy, 1'b0);
    check_eq("t8_nack", nack, 1'b0);
    repeat (5) @(negedge clk);

`ifdef LCD_PCF_CLK_STRETCH_EN
    // Slave stretches the first bit's high phase by 1000 cycles.
    begin
      int f, n;
      b = bytes_q.size();
      send(8'h50, 1'b1, 1'b0, 1'b1);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (scl !== 1'b0 && n < 200);
      check_eq("t9_scl_first_low", scl, 1'b0);
      f = cyc;
      scl_drv_low = 1'b1;
      while (cyc < f + 2 * Q + 1000) @(negedge clk);
      scl_drv_low = 1'b0;
      wait_idle("t9", 40000, dur);
      check_eq("t9_busy_len", dur, BYTE_FRAME + HOLD_S + 1000);
      check_bytes("t9", b, 5, 8'h4E, 8'h5D, 8'h59, 8'h0D, 8'h09);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
